// File: rtl/uart_pkg.sv
// uart_pkg: shared state encodings and word geometry for the UART image loader
package uart_pkg;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP} rx_state_t;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} ld_state_t;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/uart_rx.sv
// uart_rx: synchronized 8N1 receiver, 8E1 when UART_LOADER_PARITY_EN is defined
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       memclk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       stop_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
`ifdef UART_LOADER_PARITY_EN
  localparam rx_state_t AFTER_DATA = R_PARITY;
  logic par_q, par_d;
`else
  localparam rx_state_t AFTER_DATA = R_STOP;
`endif
  rx_state_t state_q, state_d;
  logic s1_q, s2_q, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic valid_q, valid_d, err_q, err_d, ok;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    bit_d = bit_q;
    sh_d = sh_q;
    valid_d = 1'b0;
    err_d = 1'b0;
`ifdef UART_LOADER_PARITY_EN
    par_d = par_q;
    ok = s2_q & ~par_q;
`else
    ok = s2_q;
`endif
    case (state_q)
      R_IDLE: begin
        cnt_d = '0;
        if (prev_q && !s2_q) state_d = R_START;
      end
      R_START: if (cnt_q == HALF) begin
        cnt_d = '0;
        bit_d = '0;
        state_d = s2_q ? R_IDLE : R_DATA;
      end
      R_DATA: if (cnt_q == FULL) begin
        cnt_d = '0;
        sh_d = {s2_q, sh_q[7:1]};
        bit_d = bit_q + 1'b1;
        state_d = (bit_q == 3'd7) ? AFTER_DATA : R_DATA;
      end
`ifdef UART_LOADER_PARITY_EN
      R_PARITY: if (cnt_q == FULL) begin
        cnt_d = '0;
        par_d = ^{sh_q, s2_q};
        state_d = R_STOP;
      end
`endif
      R_STOP: if (cnt_q == FULL) begin
        state_d = R_IDLE;
        valid_d = ok;
        err_d = ~ok;
      end
      default: state_d = R_IDLE;
    endcase
  end
  always_ff @(posedge memclk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      prev_q <= 1'b1;
      state_q <= R_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
`ifdef UART_LOADER_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      s1_q <= rx;
      s2_q <= s1_q;
      prev_q <= s2_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      valid_q <= valid_d;
      err_q <= err_d;
`ifdef UART_LOADER_PARITY_EN
      par_q <= par_d;
`endif
    end
  end
  assign byte_valid = valid_q;
  assign byte_data = sh_q;
  assign stop_err = err_q;
endmodule

// File: rtl/uart_loader.sv
// uart_loader: packs UART bytes into little-endian word writes and releases the CPU when done
// UART_LOADER_PARITY_EN switches the receiver to 8E1 framing
module uart_loader
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int WORDS        = 16384,
  parameter int ADDR_W       = 14,
  parameter int TIMEOUT_CYC  = 1_000_000
) (
  input  logic              memclk,
  input  logic              rst,
  input  logic              rx,
  input  logic              start,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              uart_finish,
  output logic              frame_err,
  output logic [ADDR_W:0]   word_cnt
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(WORDS - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  logic byte_valid, stop_err;
  logic [7:0] byte_data;
  ld_state_t state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic [31:0] wdata_q, wdata_d, pack_q, pack_d;
  logic [1:0] idx_q, idx_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic we_q, we_d, fin_q, fin_d, ferr_q, ferr_d, any_q, any_d, end_q, end_d;
  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .memclk(memclk), .rst(rst), .rx(rx),
    .byte_valid(byte_valid), .byte_data(byte_data), .stop_err(stop_err)
  );
  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    cnt_d = cnt_q;
    wdata_d = wdata_q;
    pack_d = pack_q;
    idx_d = idx_q;
    tcnt_d = (state_q == LOAD && any_q) ? tcnt_q + 1'b1 : tcnt_q;
    we_d = 1'b0;
    fin_d = fin_q;
    ferr_d = ferr_q;
    any_d = any_q;
    end_d = end_q;
    if (we_q) begin
      cnt_d = cnt_q + 1'b1;
      waddr_d = (waddr_q == LAST_ADDR) ? waddr_q : waddr_q + 1'b1;
      if (end_q || cnt_q == LAST_CNT) begin
        state_d = DONE;
        fin_d = 1'b1;
        end_d = 1'b0;
      end
    end
    if (state_q == LOAD) begin
      ferr_d = ferr_q | stop_err;
      if (byte_valid && !end_q) begin
        pack_d = (idx_q == '0) ? {24'b0, byte_data} : pack_q | (32'(byte_data) << {idx_q, 3'b000});
        idx_d = idx_q + 1'b1;
        tcnt_d = '0;
        any_d = 1'b1;
        we_d = (idx_q == 2'(BYTES_PER_WORD - 1));
        wdata_d = we_d ? pack_d : wdata_q;
      end else if (any_q && tcnt_q == T_LAST) begin
        // a partial word already has zeroed upper lanes; finish after its write completes
        any_d = 1'b0;
        we_d = (idx_q != '0);
        wdata_d = we_d ? pack_q : wdata_q;
        idx_d = '0;
        end_d = we_d;
        state_d = we_d ? LOAD : DONE;
        fin_d = ~we_d;
      end
    end
    if (start) begin
      state_d = LOAD;
      waddr_d = '0;
      cnt_d = '0;
      idx_d = '0;
      tcnt_d = '0;
      we_d = 1'b0;
      fin_d = 1'b0;
      ferr_d = 1'b0;
      any_d = 1'b0;
      end_d = 1'b0;
    end
  end
  always_ff @(posedge memclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      waddr_q <= '0;
      cnt_q <= '0;
      wdata_q <= '0;
      pack_q <= '0;
      idx_q <= '0;
      tcnt_q <= '0;
      we_q <= 1'b0;
      fin_q <= 1'b1;
      ferr_q <= 1'b0;
      any_q <= 1'b0;
      end_q <= 1'b0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      cnt_q <= cnt_d;
      wdata_q <= wdata_d;
      pack_q <= pack_d;
      idx_q <= idx_d;
      tcnt_q <= tcnt_d;
      we_q <= we_d;
      fin_q <= fin_d;
      ferr_q <= ferr_d;
      any_q <= any_d;
      end_q <= end_d;
    end
  end
  assign we = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign uart_finish = fin_q;
  assign frame_err = ferr_q;
  assign word_cnt = cnt_q;
endmodule
